// File: rtl/multi_lane_hit_scorer_if.sv
// Lane-side handshake bundle for multi_lane_hit_scorer: strobes in, pulses and HUD totals out.
// master drives the strobes (note highway / input stage); slave is the scorer itself.
interface multi_lane_hit_scorer_if #(
    parameter int NUM_LANES = 5,
    parameter int CNT_W     = 8,
    parameter int SCORE_W   = 16
);
    logic                 tick;
    logic [NUM_LANES-1:0] note_arrive;
    logic [NUM_LANES-1:0] press;
    logic [NUM_LANES-1:0] hit_pulse;
    logic [NUM_LANES-1:0] miss_pulse;
    logic [1:0]           last_acc;
    logic [SCORE_W-1:0]   score;
    logic [CNT_W-1:0]     num_hits;
    logic [CNT_W-1:0]     num_misses;
    logic [CNT_W-1:0]     combo;
    logic [CNT_W-1:0]     max_combo;

    modport master (
        output tick, note_arrive, press,
        input  hit_pulse, miss_pulse, last_acc, score,
        input  num_hits, num_misses, combo, max_combo
    );

    modport slave (
        input  tick, note_arrive, press,
        output hit_pulse, miss_pulse, last_acc, score,
        output num_hits, num_misses, combo, max_combo
    );
endinterface

// File: rtl/multi_lane_hit_scorer.sv
// N-lane hit-window scanner with saturating score/hit/miss/combo aggregation.
// Build option: define COMBO_MULT_EN to scale lane points by a combo-based multiplier (1..4).
module multi_lane_hit_scorer #(
    parameter int NUM_LANES = 5,
    parameter int WIN_LEN   = 19,
    parameter int EDGE_W    = 3,
    parameter int MID_W     = 3,
    parameter int CNT_W     = 8,
    parameter int SCORE_W   = 16
) (
    input logic                    clk,
    input logic                    rst,
    multi_lane_hit_scorer_if.slave bus
);
    localparam int CB    = $clog2(WIN_LEN + 1);
    localparam int HC_W  = $clog2(NUM_LANES + 1);
    localparam int PTS_W = $clog2(NUM_LANES * 12 + 1);

    localparam logic [CB-1:0] WIN_CNT = CB'(WIN_LEN);
    localparam logic [CB-1:0] EDGE_LO = CB'(EDGE_W);
    localparam logic [CB-1:0] EDGE_HI = CB'(WIN_LEN - EDGE_W);
    localparam logic [CB-1:0] MID_LO  = CB'(EDGE_W + MID_W);
    localparam logic [CB-1:0] MID_HI  = CB'(WIN_LEN - EDGE_W - MID_W);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } lane_state_t;

    lane_state_t          state_q [NUM_LANES];
    lane_state_t          state_d [NUM_LANES];
    logic [CB-1:0]        cnt_q   [NUM_LANES];
    logic [CB-1:0]        cnt_d   [NUM_LANES];
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] miss;

    logic [NUM_LANES-1:0] hit_q, miss_q;
    logic [1:0]           last_acc_q, last_acc_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]     hits_q, hits_d;
    logic [CNT_W-1:0]     misses_q, misses_d;
    logic [CNT_W-1:0]     combo_q, combo_d;
    logic [CNT_W-1:0]     max_combo_q, max_combo_d;

    logic [1:0]           lane_acc;
    logic [3:0]           lane_pts;
    logic [PTS_W-1:0]     pts_sum;
    logic [HC_W-1:0]      hit_cnt;
    logic [HC_W-1:0]      miss_cnt;
    logic [SCORE_W:0]     score_sum;
    logic [CNT_W:0]       hits_sum;
    logic [CNT_W:0]       misses_sum;
    logic [CNT_W:0]       combo_sum;

`ifdef COMBO_MULT_EN
    logic [CNT_W-1:0]     combo_tens;
    logic [2:0]           mult;

    // Multiplier uses the streak as it stood before this clock's events.
    always_comb begin
        combo_tens = combo_q / CNT_W'(10);
        mult       = (combo_tens >= CNT_W'(3)) ? 3'd4 : 3'(combo_tens) + 3'd1;
    end
`endif

    function automatic logic [1:0] grade(input logic [CB-1:0] c);
        if (c <= EDGE_LO || c > EDGE_HI)
            return 2'd1;
        else if (c <= MID_LO || c > MID_HI)
            return 2'd2;
        else
            return 2'd3;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= IDLE;
                cnt_q[l]   <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= state_d[l];
                cnt_q[l]   <= cnt_d[l];
            end
        end
    end

    // A note arriving on an open lane first resolves the old window (hit or miss), then reopens.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            state_d[l] = state_q[l];
            cnt_d[l]   = cnt_q[l];
            hit[l]     = 1'b0;
            miss[l]    = 1'b0;
            case (state_q[l])
                IDLE: begin
                    miss[l] = bus.press[l];
                    if (bus.note_arrive[l]) begin
                        state_d[l] = OPEN;
                        cnt_d[l]   = CB'(1);
                    end
                end
                OPEN: begin
                    if (bus.press[l]) begin
                        hit[l]     = 1'b1;
                        state_d[l] = IDLE;
                        cnt_d[l]   = '0;
                    end else if (bus.note_arrive[l]) begin
                        miss[l] = 1'b1;
                    end else if (bus.tick) begin
                        if (cnt_q[l] == WIN_CNT) begin
                            miss[l]    = 1'b1;
                            state_d[l] = IDLE;
                            cnt_d[l]   = '0;
                        end else begin
                            cnt_d[l] = cnt_q[l] + CB'(1);
                        end
                    end
                    if (bus.note_arrive[l]) begin
                        state_d[l] = OPEN;
                        cnt_d[l]   = CB'(1);
                    end
                end
                default: begin
                    state_d[l] = IDLE;
                    cnt_d[l]   = '0;
                end
            endcase
        end
    end

    // Ascending lane scan lets the highest-index hit own last_acc.
    always_comb begin
        lane_acc   = '0;
        lane_pts   = '0;
        pts_sum    = '0;
        hit_cnt    = '0;
        miss_cnt   = '0;
        last_acc_d = last_acc_q;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            lane_acc = grade(cnt_q[l]);
`ifdef COMBO_MULT_EN
            lane_pts = 4'(lane_acc) * 4'(mult);
`else
            lane_pts = 4'(lane_acc);
`endif
            if (hit[l]) begin
                hit_cnt    = hit_cnt + HC_W'(1);
                pts_sum    = pts_sum + PTS_W'(lane_pts);
                last_acc_d = lane_acc;
            end
            if (miss[l])
                miss_cnt = miss_cnt + HC_W'(1);
        end

        score_sum  = {1'b0, score_q}  + (SCORE_W + 1)'(pts_sum);
        hits_sum   = {1'b0, hits_q}   + (CNT_W + 1)'(hit_cnt);
        misses_sum = {1'b0, misses_q} + (CNT_W + 1)'(miss_cnt);
        combo_sum  = {1'b0, combo_q}  + (CNT_W + 1)'(hit_cnt);

        score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        hits_d   = hits_sum[CNT_W]    ? '1 : hits_sum[CNT_W-1:0];
        misses_d = misses_sum[CNT_W]  ? '1 : misses_sum[CNT_W-1:0];

        if (|miss)
            combo_d = '0;
        else
            combo_d = combo_sum[CNT_W] ? '1 : combo_sum[CNT_W-1:0];

        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q       <= '0;
            miss_q      <= '0;
            last_acc_q  <= '0;
            score_q     <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            hit_q       <= hit;
            miss_q      <= miss;
            last_acc_q  <= last_acc_d;
            score_q     <= score_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.last_acc   = last_acc_q;
    assign bus.score      = score_q;
    assign bus.num_hits   = hits_q;
    assign bus.num_misses = misses_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
endmodule

// File: tb/tb_multi_lane_hit_scorer.sv
// Self-checking bench for multi_lane_hit_scorer: directed scenarios plus random traffic
// against a per-lane note-age reference model.
module tb_multi_lane_hit_scorer;
    localparam int NL   = 5;
    localparam int WIN  = 19;
    localparam int EDGE = 3;
    localparam int MID  = 3;
    localparam int CW   = 8;
    localparam int SW   = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int SMAX = (1 << SW) - 1;
    localparam int VW   = 2 * NL + 2 + SW + 4 * CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_lane_hit_scorer_if #(.NUM_LANES(NL), .CNT_W(CW), .SCORE_W(SW)) bus ();

    multi_lane_hit_scorer #(
        .NUM_LANES(NL), .WIN_LEN(WIN), .EDGE_W(EDGE), .MID_W(MID), .CNT_W(CW), .SCORE_W(SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: which lanes hold a live note and how old it is (1 on the clk after arrival).
    bit          m_open [NL];
    int          m_age  [NL];
    logic [NL-1:0] e_hit, e_miss;
    logic [1:0]  e_last;
    int          e_score, e_hits, e_misses, e_combo, e_max;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {bus.hit_pulse, bus.miss_pulse, bus.last_acc, bus.score,
                      bus.num_hits, bus.num_misses, bus.combo, bus.max_combo};

    function automatic logic [VW-1:0] exp_vec();
        return {e_hit, e_miss, e_last, SW'(e_score), CW'(e_hits), CW'(e_misses),
                CW'(e_combo), CW'(e_max)};
    endfunction

    // Accuracy from the distance to the nearer end of the window.
    function automatic int grade(int c);
        int d;
        d = (c < WIN + 1 - c) ? c : WIN + 1 - c;
        if (d <= EDGE) return 1;
        if (d <= EDGE + MID) return 2;
        return 3;
    endfunction

    task automatic model_step(input logic r, input logic tk, input logic [NL-1:0] na,
                              input logic [NL-1:0] pr);
        int pts, nh, nm, mult, a;
        if (r) begin
            for (int l = 0; l < NL; l++) begin
                m_open[l] = 0;
                m_age[l]  = 0;
            end
            e_hit = '0; e_miss = '0; e_last = '0;
            e_score = 0; e_hits = 0; e_misses = 0; e_combo = 0; e_max = 0;
            return;
        end
        mult = 1;
`ifdef COMBO_MULT_EN
        mult = 1 + ((e_combo / 10 < 3) ? e_combo / 10 : 3);
`endif
        pts = 0; nh = 0; nm = 0;
        e_hit = '0; e_miss = '0;
        for (int l = 0; l < NL; l++) begin
            if (m_open[l] && pr[l]) begin
                a = grade(m_age[l]);
                e_hit[l] = 1'b1; nh++; pts += a * mult; e_last = 2'(a);
                m_open[l] = 0;
            end else if (pr[l]) begin
                e_miss[l] = 1'b1; nm++;
            end else if (m_open[l] && (na[l] || (tk && m_age[l] == WIN))) begin
                e_miss[l] = 1'b1; nm++;
                m_open[l] = 0;
            end else if (m_open[l] && tk) begin
                m_age[l]++;
            end
            if (na[l]) begin
                m_open[l] = 1;
                m_age[l]  = 1;
            end
        end
        e_hits   = (e_hits + nh > CMAX) ? CMAX : e_hits + nh;
        e_misses = (e_misses + nm > CMAX) ? CMAX : e_misses + nm;
        e_score  = (e_score + pts > SMAX) ? SMAX : e_score + pts;
        e_combo  = (nm != 0) ? 0 : ((e_combo + nh > CMAX) ? CMAX : e_combo + nh);
        if (e_combo > e_max) e_max = e_combo;
    endtask

    task automatic cycle(input logic r, input logic tk, input logic [NL-1:0] na,
                         input logic [NL-1:0] pr);
        rst = r; bus.tick = tk; bus.note_arrive = na; bus.press = pr;
        model_step(r, tk, na, pr);
        @(posedge clk);
        #1;
        rst = 1'b0; bus.tick = 1'b0; bus.note_arrive = '0; bus.press = '0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (dut_vec !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
    endtask

    task automatic test_single_hit();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'b00001, '0);
        for (int j = 0; j < 9; j++) cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, '0, 5'b00001);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL single_hit_model: got %h expected %h", dut_vec, exp_vec());
        end
        total++;
        if ({bus.hit_pulse, bus.last_acc, bus.score, bus.num_hits, bus.combo} !==
            {5'b00001, 2'd3, 16'd3, 8'd1, 8'd1}) begin
            bad++;
            $display("FAIL single_hit_values: hit=%b acc=%0d score=%0d hits=%0d combo=%0d expected 00001/3/3/1/1",
                     bus.hit_pulse, bus.last_acc, bus.score, bus.num_hits, bus.combo);
        end
    endtask

    task automatic test_expiry();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'b00100, '0);
        for (int j = 1; j <= 19; j++) begin
            cycle(1'b0, 1'b1, '0, '0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL expiry_tick%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
        end
        total++;
        if ({bus.miss_pulse, bus.num_misses, bus.combo} !== {5'b00100, 8'd1, 8'd0}) begin
            bad++;
            $display("FAIL expiry_values: miss=%b misses=%0d combo=%0d expected 00100/1/0",
                     bus.miss_pulse, bus.num_misses, bus.combo);
        end
    endtask

    task automatic test_stray_and_grading();
        int cnts [4] = '{2, 5, 15, 19};
        int accs [4] = '{1, 2, 2, 1};
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, '0, 5'b00010);
        total++;
        if ({bus.miss_pulse, bus.num_misses} !== {5'b00010, 8'd1}) begin
            bad++;
            $display("FAIL stray_press: miss=%b misses=%0d expected 00010/1", bus.miss_pulse, bus.num_misses);
        end
        for (int j = 0; j < 22; j++) cycle(1'b0, 1'b1, '0, '0);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL stray_no_window: got %h expected %h", dut_vec, exp_vec());
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 5'b00010, '0);
            for (int j = 1; j < cnts[k]; j++) cycle(1'b0, 1'b1, '0, '0);
            cycle(1'b0, 1'b1, '0, 5'b00010);
            total++;
            if (bus.last_acc !== 2'(accs[k]) || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL grade_cnt%0d: acc=%0d vec=%h expected acc=%0d vec=%h",
                         cnts[k], bus.last_acc, dut_vec, accs[k], exp_vec());
            end
        end
    endtask

    task automatic test_same_clk();
        int s0;
        cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 5'b00001, '0);
            cycle(1'b0, 1'b1, '0, 5'b00001);
        end
        s0 = int'(bus.score);
        cycle(1'b0, 1'b1, 5'b01000, '0);
        for (int j = 1; j <= 19; j++)
            cycle(1'b0, 1'b1, (j == 9) ? 5'b00001 : 5'b00000, (j == 19) ? 5'b00001 : 5'b00000);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL same_clk_model: got %h expected %h", dut_vec, exp_vec());
        end
        total++;
        if (int'(bus.score) != s0 + 3 || bus.num_hits !== 8'd5 || bus.num_misses !== 8'd1 ||
            bus.combo !== 8'd0 || bus.max_combo < 8'd4) begin
            bad++;
            $display("FAIL same_clk_values: score=%0d hits=%0d misses=%0d combo=%0d max=%0d expected %0d/5/1/0/>=4",
                     bus.score, bus.num_hits, bus.num_misses, bus.combo, bus.max_combo, s0 + 3);
        end
    endtask

    task automatic test_priorities();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'b10000, '0);
        for (int j = 0; j < 4; j++) cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, 5'b10000, 5'b10000);
        total++;
        if (bus.hit_pulse !== 5'b10000 || bus.last_acc !== 2'd2 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL note_and_press: hit=%b acc=%0d vec=%h expected 10000/2 vec=%h",
                     bus.hit_pulse, bus.last_acc, dut_vec, exp_vec());
        end
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b1, 5'b10000, '0);
        total++;
        if (bus.miss_pulse !== 5'b10000 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL renote_miss: miss=%b vec=%h expected 10000 vec=%h", bus.miss_pulse, dut_vec, exp_vec());
        end
        for (int j = 0; j < 18; j++) cycle(1'b0, 1'b1, '0, '0);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, '0, '0);
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL hold_no_tick: got %h expected %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 1'b1, '0, 5'b10000);
        total++;
        if (bus.hit_pulse !== 5'b10000 || bus.miss_pulse !== 5'b00000 || bus.last_acc !== 2'd1) begin
            bad++;
            $display("FAIL expiry_press: hit=%b miss=%b acc=%0d expected 10000/00000/1",
                     bus.hit_pulse, bus.miss_pulse, bus.last_acc);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 1'b1, '1, '0);
            cycle(1'b0, 1'b1, '0, '1);
        end
        total++;
        if (bus.num_hits !== 8'd255 || bus.combo !== 8'd255 || bus.max_combo !== 8'd255 ||
            dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL saturation: hits=%0d combo=%0d max=%0d vec=%h expected 255/255/255 vec=%h",
                     bus.num_hits, bus.combo, bus.max_combo, dut_vec, exp_vec());
        end
    endtask

`ifdef COMBO_MULT_EN
    task automatic test_combo_mult();
        int s0;
        cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, '1, '0);
            cycle(1'b0, 1'b1, '0, '1);
        end
        cycle(1'b0, 1'b1, 5'b00001, '0);
        for (int j = 0; j < 9; j++) cycle(1'b0, 1'b1, '0, '0);
        s0 = int'(bus.score);
        cycle(1'b0, 1'b1, '0, 5'b00001);
        total++;
        if (int'(bus.score) != s0 + 9 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL combo_mult: score=%0d expected %0d", bus.score, s0 + 9);
        end
    endtask
`endif

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'b00010, '0);
        cycle(1'b0, 1'b1, '0, 5'b00010);
        cycle(1'b0, 1'b1, 5'b00001, '0);
        for (int j = 0; j < 7; j++) cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b1, 1'b1, '0, '0);
        total++;
        if (dut_vec !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %h expected 0", dut_vec);
        end
        for (int j = 0; j < 30; j++) begin
            cycle(1'b0, 1'b1, '0, '0);
            total++;
            if (bus.miss_pulse !== '0 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_quiet%0d: miss=%b vec=%h expected 0 vec=%h",
                         j, bus.miss_pulse, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [NL-1:0] na, pr;
        logic tk, r;
        cycle(1'b1, 1'b0, '0, '0);
        for (int n = 0; n < 3000; n++) begin
            for (int l = 0; l < NL; l++) begin
                na[l] = ($urandom_range(0, 15) == 0);
                pr[l] = ($urandom_range(0, 9) == 0);
            end
            tk = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 499) == 0);
            cycle(r, tk, na, pr);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d: got %h expected %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.note_arrive = '0;
        bus.press = '0;
        test_reset();
        test_single_hit();
        test_expiry();
        test_stray_and_grading();
        test_same_clk();
        test_priorities();
        test_saturation();
`ifdef COMBO_MULT_EN
        test_combo_mult();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t exceeded limit, bad=%0d", $time, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
